wr_ctrl: RTL

WR_CTRL -- requirements
Module: wr_ctrl

---
 rtl/wr_ctrl.sv | 54 +++++
 1 files changed

// File: rtl/wr_ctrl.sv
// wr_ctrl: FIFO write-side controller with wrap-bit pointer, flags and registered memory write port
module wr_ctrl #(
  parameter int W_DATA_WIDTH = 16,
  parameter int MEM_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int AF_THRESH    = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_request,
  input  logic [W_DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]     rd_ptr,
  output logic [ADDR_WIDTH:0]     wr_ptr,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [W_DATA_WIDTH-1:0] mem_wr_data,
  output logic                    full_flag,
  output logic                    almost_full,
  output logic [ADDR_WIDTH:0]     fill_level,
  output logic                    overflow
);
  localparam int STEP = W_DATA_WIDTH / MEM_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] STEP_W  = (ADDR_WIDTH+2)'(STEP);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_W = (ADDR_WIDTH+2)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH+1:0] AF_W    = (ADDR_WIDTH+2)'(AF_THRESH);
  logic [ADDR_WIDTH+1:0] free_slots;
  logic                  accept;
  // occupancy, flags and write acceptance from the pointers as they stand this cycle
  always_comb begin
    fill_level  = wr_ptr - rd_ptr;
    free_slots  = DEPTH_W - {1'b0, fill_level};
    full_flag   = free_slots < STEP_W;
    almost_full = {1'b0, fill_level} >= AF_W;
    accept      = wr_request & ~full_flag;
  end
  // pointer advance, one-cycle memory write strobe and sticky dropped-write flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      overflow    <= 1'b0;
    end else begin
      mem_wr_en <= accept;
      overflow  <= overflow | (wr_request & full_flag);
      if (accept) begin
        wr_ptr      <= wr_ptr + STEP_W[ADDR_WIDTH:0];
        mem_wr_addr <= wr_ptr[ADDR_WIDTH-1:0];
        mem_wr_data <= wr_data;
      end
    end
  end
endmodule
